// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
interface icache_if;
    logic        if_icache_en_in;
    logic [31:0] if_icache_inst_addr_in;
    logic        icache_if_rdy_out;
    logic        icache_if_miss_out;
    logic [31:0] icache_if_inst_inst_out;
    logic        rob_icache_rst_in;
    logic        icache_memctrl_en_out;
    logic [31:0] icache_memctrl_addr_out;
    logic        memctrl_icache_gnt_in;
    logic        memctrl_icache_valid_in;
    logic [7:0]  memctrl_icache_data_in;

    modport slave (
        input  if_icache_en_in, if_icache_inst_addr_in, rob_icache_rst_in,
        input  memctrl_icache_gnt_in, memctrl_icache_valid_in, memctrl_icache_data_in,
        output icache_if_rdy_out, icache_if_miss_out, icache_if_inst_inst_out,
        output icache_memctrl_en_out, icache_memctrl_addr_out
    );

    modport master (
        output if_icache_en_in, if_icache_inst_addr_in, rob_icache_rst_in,
        output memctrl_icache_gnt_in, memctrl_icache_valid_in, memctrl_icache_data_in,
        input  icache_if_rdy_out, icache_if_miss_out, icache_if_inst_inst_out,
        input  icache_memctrl_en_out, icache_memctrl_addr_out
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache; misses are filled byte by byte.
// Define ICACHE_STAT_EN to add hit/miss counter outputs.
module icache #(
    parameter int ADDR_WIDTH  = 18,
    parameter int INDEX_WIDTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    icache_if.slave     bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] icache_hit_cnt_out,
    output logic [31:0] icache_miss_cnt_out
`endif
);
    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - 2;
    localparam int WORD_WIDTH = ADDR_WIDTH - 2;
    localparam int LINES      = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                 state;
    logic [LINES-1:0]       line_vld;
    logic [TAG_WIDTH-1:0]   line_tag  [LINES];
    logic [31:0]            line_data [LINES];

    logic [WORD_WIDTH-1:0]  word_addr;
    logic [1:0]             k;
    logic                   in_flight;
    logic [23:0]            fill_buf;
    logic                   rdy_q;
    logic                   miss_q;
    logic                   mem_en_q;
    logic [31:0]            mem_addr_q;
    logic [31:0]            inst_q;

    logic [INDEX_WIDTH-1:0] req_index;
    logic [INDEX_WIDTH-1:0] fill_index;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [TAG_WIDTH-1:0]   fill_tag;
    logic                   req_hit;
    logic                   req_accept;
    logic                   flush;
    logic                   byte_ret;
    logic                   fill_done;
    logic [1:0]             byte_sel;

    assign req_index  = bus.if_icache_inst_addr_in[INDEX_WIDTH+1:2];
    assign req_tag    = bus.if_icache_inst_addr_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign req_hit    = line_vld[req_index] && (line_tag[req_index] == req_tag);
    assign flush      = bus.rob_icache_rst_in;
    assign req_accept = (state == IDLE) && bus.if_icache_en_in && !flush;
    assign fill_index = word_addr[INDEX_WIDTH-1:0];
    assign fill_tag   = word_addr[WORD_WIDTH-1:INDEX_WIDTH];
    assign byte_ret   = (state == FILL) && in_flight && bus.memctrl_icache_valid_in;
    // k counts granted bytes, so the returning byte is the one before it
    assign byte_sel   = k - 2'd1;
    assign fill_done  = byte_ret && (byte_sel == 2'd3) && !flush;

    assign bus.icache_if_rdy_out       = rdy_q;
    assign bus.icache_if_miss_out      = miss_q;
    assign bus.icache_if_inst_inst_out = inst_q;
    assign bus.icache_memctrl_en_out   = mem_en_q;
    assign bus.icache_memctrl_addr_out = mem_addr_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            line_vld   <= '0;
            k          <= 2'd0;
            in_flight  <= 1'b0;
            rdy_q      <= 1'b0;
            miss_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            inst_q     <= '0;
`ifdef ICACHE_STAT_EN
            icache_hit_cnt_out  <= '0;
            icache_miss_cnt_out <= '0;
`endif
        end else if (rdy_in) begin
            rdy_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_accept) begin
                        if (req_hit) begin
                            rdy_q  <= 1'b1;
                            inst_q <= line_data[req_index];
`ifdef ICACHE_STAT_EN
                            icache_hit_cnt_out <= icache_hit_cnt_out + 32'd1;
`endif
                        end else begin
                            miss_q     <= 1'b1;
                            k          <= 2'd0;
                            in_flight  <= 1'b0;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= {{(32-ADDR_WIDTH){1'b0}},
                                           bus.if_icache_inst_addr_in[ADDR_WIDTH-1:2], 2'b00};
                            state      <= FILL;
`ifdef ICACHE_STAT_EN
                            icache_miss_cnt_out <= icache_miss_cnt_out + 32'd1;
`endif
                        end
                    end
                end
                FILL: begin
                    if (flush) begin
                        // a byte granted now or still outstanding must be drained first
                        mem_en_q  <= 1'b0;
                        in_flight <= 1'b0;
                        if ((in_flight && !bus.memctrl_icache_valid_in) ||
                            (mem_en_q && bus.memctrl_icache_gnt_in))
                            state <= DRAIN;
                        else
                            state <= IDLE;
                    end else if (mem_en_q && bus.memctrl_icache_gnt_in) begin
                        mem_en_q  <= 1'b0;
                        in_flight <= 1'b1;
                        k         <= k + 2'd1;
                    end else if (byte_ret) begin
                        in_flight <= 1'b0;
                        if (byte_sel == 2'd3) begin
                            rdy_q               <= 1'b1;
                            inst_q              <= {bus.memctrl_icache_data_in, fill_buf};
                            line_vld[fill_index] <= 1'b1;
                            state               <= IDLE;
                        end else begin
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= {{(32-ADDR_WIDTH){1'b0}}, word_addr, k};
                        end
                    end
                end
                DRAIN: begin
                    if (bus.memctrl_icache_valid_in)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath storage: not reset; validity is tracked by line_vld and state
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (req_accept && !req_hit)
                word_addr <= bus.if_icache_inst_addr_in[ADDR_WIDTH-1:2];
            if (byte_ret) begin
                case (byte_sel)
                    2'd0:    fill_buf[7:0]   <= bus.memctrl_icache_data_in;
                    2'd1:    fill_buf[15:8]  <= bus.memctrl_icache_data_in;
                    2'd2:    fill_buf[23:16] <= bus.memctrl_icache_data_in;
                    default: ;
                endcase
            end
            if (fill_done) begin
                line_data[fill_index] <= {bus.memctrl_icache_data_in, fill_buf};
                line_tag[fill_index]  <= fill_tag;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: byte-wide memory controller responder plus a tag/valid reference model.
module tb_icache;
    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    icache_if bus ();
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
`ifdef ICACHE_STAT_EN
        ,
        .icache_hit_cnt_out  (hit_cnt),
        .icache_miss_cnt_out (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          pulse_cnt = 0;

    logic [7:0]  mem [0:131071];
    bit          m_vld [256];
    logic [7:0]  m_tag [256];
    int          m_hits = 0;
    int          m_misses = 0;

    int          mphase;
    int          gdelay;
    int          rdelay;
    bit          mfixed;
    logic [31:0] lat_addr;
    logic [31:0] mq [$];
    int unsigned last_vld_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [16:0] b;
        b = {a[16:2], 2'b00};
        return {mem[b + 17'd3], mem[b + 17'd2], mem[b + 17'd1], mem[b]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && rdy && (bus.icache_if_rdy_out || bus.icache_if_miss_out)) begin
            pulse_cnt <= pulse_cnt + 1;
            chk("rdy_miss_exclusive", 32'(bus.icache_if_rdy_out & bus.icache_if_miss_out), 0);
        end
    end

    // Memory controller: one byte at a time, grant after gdelay, data after rdelay
    initial begin
        bus.memctrl_icache_gnt_in   = 1'b0;
        bus.memctrl_icache_valid_in = 1'b0;
        bus.memctrl_icache_data_in  = 8'h00;
        mphase = 0; gdelay = 0; rdelay = 0; last_vld_edge = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.memctrl_icache_gnt_in   = 1'b0;
                bus.memctrl_icache_valid_in = 1'b0;
                mphase = 0;
            end else if (rdy) begin
                bus.memctrl_icache_gnt_in   = 1'b0;
                bus.memctrl_icache_valid_in = 1'b0;
                if (mphase == 1) begin
                    chk("en_out_while_in_flight", 32'(bus.icache_memctrl_en_out), 0);
                    if (rdelay == 0) begin
                        bus.memctrl_icache_valid_in = 1'b1;
                        bus.memctrl_icache_data_in  = mem[lat_addr[16:0]];
                        mphase = 0;
                        last_vld_edge = cyc + 1;
                        gdelay = mfixed ? 0 : int'($urandom_range(0, 2));
                    end else begin
                        rdelay--;
                    end
                end else if (bus.icache_memctrl_en_out) begin
                    if (gdelay == 0) begin
                        bus.memctrl_icache_gnt_in = 1'b1;
                        lat_addr = bus.icache_memctrl_addr_out;
                        mq.push_back(bus.icache_memctrl_addr_out);
                        mphase = 1;
                        rdelay = mfixed ? 0 : int'($urandom_range(0, 2));
                    end else begin
                        gdelay--;
                    end
                end
            end
        end
    end

    task automatic send_req(input logic [31:0] a, output bit hit);
        logic [7:0] idx;
        logic [7:0] tg;
        idx = a[9:2];
        tg  = a[17:10];
        hit = m_vld[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        mq.delete();
        bus.if_icache_en_in        = 1'b1;
        bus.if_icache_inst_addr_in = a;
        @(negedge clk);
        bus.if_icache_en_in        = 1'b0;
        bus.if_icache_inst_addr_in = $urandom;
        chk("rdy_out", 32'(bus.icache_if_rdy_out), 32'(hit));
        chk("miss_out", 32'(bus.icache_if_miss_out), 32'(!hit));
        if (hit) begin
            chk("hit_inst", bus.icache_if_inst_inst_out, word_at(a));
            chk("hit_no_mem_req", 32'(bus.icache_memctrl_en_out), 0);
            m_hits++;
        end else begin
            m_misses++;
        end
    endtask

    task automatic await_fill(input logic [31:0] a);
        bit seen;
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.icache_if_rdy_out) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            chk("fill_timeout", 0, 1);
        end else begin
            chk("fill_inst", bus.icache_if_inst_inst_out, word_at(a));
            chk("fill_latency", cyc, last_vld_edge);
            chk("fill_nbytes", mq.size(), 4);
            foreach (mq[i]) chk("fill_byte_addr", mq[i], {a[31:2], 2'b00} + i);
            m_vld[a[9:2]] = 1'b1;
            m_tag[a[9:2]] = a[17:10];
            @(negedge clk);
            chk("fill_pulse_len", 32'(bus.icache_if_rdy_out), 0);
            chk("fill_inst_hold", bus.icache_if_inst_inst_out, word_at(a));
        end
    endtask

    task automatic do_fetch(input logic [31:0] a);
        bit h;
        send_req(a, h);
        if (!h) await_fill(a);
    endtask

    task automatic flush_idle(input logic [31:0] a);
        @(negedge clk);
        bus.if_icache_en_in        = 1'b1;
        bus.if_icache_inst_addr_in = a;
        bus.rob_icache_rst_in      = 1'b1;
        @(negedge clk);
        bus.if_icache_en_in   = 1'b0;
        bus.rob_icache_rst_in = 1'b0;
        chk("flush_idle_rdy", 32'(bus.icache_if_rdy_out), 0);
        chk("flush_idle_miss", 32'(bus.icache_if_miss_out), 0);
        chk("flush_idle_en", 32'(bus.icache_memctrl_en_out), 0);
    endtask

    task automatic flush_mid_fill(input logic [31:0] a);
        bit h;
        bit found;
        int p0;
        send_req(a, h);
        if (!h) begin
            found = 0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (mq.size() == 2 && mphase == 1) begin
                    found = 1;
                    break;
                end
            end
            if (!found) chk("flush_wait_timeout", 0, 1);
            bus.rob_icache_rst_in = 1'b1;
            @(posedge clk);
            #1;
            p0 = pulse_cnt;
            @(negedge clk);
            bus.rob_icache_rst_in = 1'b0;
            repeat (12) @(negedge clk);
            @(posedge clk);
            #1;
            chk("flush_no_response", pulse_cnt - p0, 0);
            chk("flush_en_idle", 32'(bus.icache_memctrl_en_out), 0);
            chk("flush_drained", mphase, 0);
        end
    endtask

    task automatic freeze_fill(input logic [31:0] a);
        bit h;
        logic e0;
        logic [31:0] a0;
        send_req(a, h);
        if (!h) begin
            @(posedge clk);
            #1;
            rdy = 1'b0;
            e0 = bus.icache_memctrl_en_out;
            a0 = bus.icache_memctrl_addr_out;
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("freeze_en", 32'(bus.icache_memctrl_en_out), 32'(e0));
                chk("freeze_addr", bus.icache_memctrl_addr_out, a0);
            end
            rdy = 1'b1;
            await_fill(a);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rdy"},  32'(bus.icache_if_rdy_out), 0);
        chk({tag, "_miss"}, 32'(bus.icache_if_miss_out), 0);
        chk({tag, "_en"},   32'(bus.icache_memctrl_en_out), 0);
        chk({tag, "_addr"}, bus.icache_memctrl_addr_out, 0);
        chk({tag, "_inst"}, bus.icache_if_inst_inst_out, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        logic [31:0] a;
        int r;
        rst_n = 1'b1;
        rdy = 1'b1;
        mfixed = 1'b1;
        bus.if_icache_en_in        = 1'b0;
        bus.if_icache_inst_addr_in = '0;
        bus.rob_icache_rst_in      = 1'b0;
        for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            m_vld[i] = 1'b0;
            m_tag[i] = 8'h00;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
`ifdef ICACHE_STAT_EN
        chk("reset_hit_cnt", hit_cnt, 0);
        chk("reset_miss_cnt", miss_cnt, 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Flush with the 2nd byte in flight leaves line 0 unwritten
        flush_mid_fill(32'h0000_0000);
        do_fetch(32'h0000_0000);
        chk("cold_inst_value", bus.icache_if_inst_inst_out, 32'h0000_0513);

        send_req(32'h0000_0000, h);
        @(negedge clk);
        chk("hit_pulse_len", 32'(bus.icache_if_rdy_out), 0);
        chk("hit_inst_hold", bus.icache_if_inst_inst_out, 32'h0000_0513);
        chk("hit_en_quiet", 32'(bus.icache_memctrl_en_out), 0);

        do_fetch(32'h0000_0004);
        do_fetch(32'h0000_0404);
        do_fetch(32'h0000_0004);

        do_fetch(32'h0000_03FC);
        do_fetch(32'h0000_0000);
        do_fetch(32'h0000_03FC);

        flush_idle(32'h0000_0008);
        do_fetch(32'h0000_0008);

        mfixed = 1'b0;
        freeze_fill(32'h0000_0010);

        for (int it = 0; it < 60; it++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2) |
                32'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            if (r == 0)      flush_idle(a);
            else if (r == 1) flush_mid_fill(a);
            else             do_fetch(a);
        end

`ifdef ICACHE_STAT_EN
        @(negedge clk);
        chk("stat_hits", hit_cnt, m_hits);
        chk("stat_misses", miss_cnt, m_misses);
`endif

        do_fetch(32'h0000_0000);
        send_req(32'h0000_1F00, h);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
`ifdef ICACHE_STAT_EN
        chk("async_reset_hit_cnt", hit_cnt, 0);
        chk("async_reset_miss_cnt", miss_cnt, 0);
`endif
        for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_fetch(32'h0000_0000);
`ifdef ICACHE_STAT_EN
        @(negedge clk);
        chk("post_reset_misses", miss_cnt, m_misses);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
